counter_sequencer: RTL
======================

# counter_sequencer

Command-driven controller for the 4-bit up/down loadable counter. It accepts LOAD, UP-by-N, DOWN-by-N and NOP commands over a valid/ready handshake, and sequences the counter's Load, Enable, UpDn and Data inputs. It then checks the counter's Q against a self-computed expected value, so it can sit between a host/test sequencer and counter instance U1 as a self-checking front end.

## Interface
- WIDTH, 4: counter width; also the width of CmdArg, Data, Q, Expect.
- ERRW, 8: width of ErrCount.

- Clk  input  1  clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-high reset.
- CmdValid  input  1  command offered.
- CmdReady  output  1  controller can accept a command; 1 only in IDLE.
- CmdOp  input  2  00=LOAD, 01=UP, 10=DOWN, 11=NOP.
- CmdArg  input  WIDTH  load value (LOAD) or step count N (UP/DOWN); ignored for NOP.
- Abort  input  1  cancel the current command.
- Load  output  1  counter parallel-load strobe.
- Data  output  WIDTH  counter load value.
- Enable  output  1  counter count enable.
- UpDn  output  1  counter direction, 1=up.
- Q  input  WIDTH  counter output.
- Busy  output  1  state != IDLE.
- Done  output  1  command-complete strobe, high for 1 cycle.
- Mismatch  output  1  valid only while Done=1; 1 when Q != Expect.
- Expect  output  WIDTH  registered expected counter value.
- ErrCount  output  ERRW  saturating count of mismatches.

## Operation
- Counter contract: at a posedge, Load=1 sets Q=Data (Load has priority). Otherwise Enable=1 steps Q by ±1 mod 2^WIDTH in the UpDn direction. Otherwise Q holds.
- FSM states: IDLE, LOAD, COUNT, CHECK. Outputs decode from registered state/regs.
- IDLE:
  - CmdReady=1.
  - On CmdValid&CmdReady: latch op; latch Arg into Remain.
  - Set Expect: LOAD→CmdArg; UP→Q+CmdArg; DOWN→Q−CmdArg; NOP→Q. All mod 2^WIDTH, truncated to WIDTH.
  - Next state: LOAD→LOAD; UP/DOWN with CmdArg≠0→COUNT; UP/DOWN with CmdArg=0, or NOP→CHECK.
- LOAD: Load=1, Data=latched arg, for exactly 1 cycle; then CHECK.
- COUNT: Enable=1, UpDn=(op==UP). Remain decrements each cycle. Leave for CHECK on the cycle Remain==1, giving exactly N Enable cycles.
- CHECK: Done=1, Mismatch=(Q!=Expect). If Mismatch, ErrCount increments; it saturates at all-ones. Next state is IDLE.
- Outside their states: Load=0, Enable=0, UpDn=0, Data=0.
- Abort (sampled at posedge):
  - In LOAD or COUNT: go to IDLE next cycle, with no Done and no ErrCount change.
  - In CHECK: ignored; completion is not cancelled.
  - In IDLE: Abort has priority over acceptance, so no command is accepted that cycle.
- CmdOp/CmdArg are sampled only on the accept edge. Later changes have no effect.

## Timing
- Reset (async, immediate): state=IDLE, Load=Enable=UpDn=0, Data=0, Busy=0, Done=0, Mismatch=0, Expect=0, ErrCount=0, Remain=0. CmdReady=1 after reset deasserts.
- Reset mid-command: the command is abandoned, with no Done. Q is left wherever the counter stands.
- Latency, accept edge to first Done cycle:
  - LOAD: 2 cycles.
  - UP/DOWN with N≥1: N+1 cycles.
  - NOP or N=0: 1 cycle.
- After Done there is 1 IDLE cycle before the next accept, so the minimum command spacing is latency+1.
- The Q compare in CHECK sees the counter's value after its final update edge.
- Wrap-around: UP from 4'hE by 3 gives Expect=4'h1. DOWN from 4'h1 by 2 gives Expect=4'hF. Both are legal, not errors.

## Test plan
- Reset, then LOAD 4'h3. Required: Load=1, Data=3 for exactly 1 cycle; Done 2 cycles after accept; Q=3, Mismatch=0, Expect=3.
- After LOAD 4'hE, issue UP N=3. Required: Enable=1, UpDn=1 for exactly 3 cycles; Done at accept+4; Q=4'h1=Expect; Mismatch=0.
- Issue DOWN N=0 then NOP. Required: each gives Done 1 cycle after accept, with Enable never asserted, Expect=Q, and 1 IDLE cycle between them.
- Force the counter's Q to a stale value (model stuck) during UP N=2. Required: Mismatch=1 on Done and ErrCount increments 0→1. Preload ErrCount near all-ones via repeated mismatches; required: it saturates at 8'hFF.
- Assert Abort in the 2nd cycle of UP N=5. Required: Enable drops the next cycle, no Done pulse, CmdReady=1, ErrCount unchanged.
- Assert Reset asynchronously mid-COUNT (between edges). Required: Enable=0, Busy=0, Expect=0 immediately, before the next Clk edge; a new LOAD after release completes normally.

Source files
------------

// File: rtl/counter_sequencer.sv
// Command-driven front end for a 4-bit up/down loadable counter: sequences Load/Enable/UpDn/Data
// from LOAD/UP/DOWN/NOP commands and checks the counter's Q against a self-computed expectation.
module counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int ERRW  = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [1:0]       CmdOp,
    input  logic [WIDTH-1:0] CmdArg,
    input  logic             Abort,
    output logic             Load,
    output logic [WIDTH-1:0] Data,
    output logic             Enable,
    output logic             UpDn,
    input  logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic             Mismatch,
    output logic [WIDTH-1:0] Expect,
    output logic [ERRW-1:0]  ErrCount
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam logic [1:0]       OP_LOAD = 2'b00;
    localparam logic [1:0]       OP_UP   = 2'b01;
    localparam logic [1:0]       OP_DOWN = 2'b10;
    localparam logic [1:0]       OP_NOP  = 2'b11;
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERRW-1:0]  ERR_MAX = {ERRW{1'b1}};
    localparam logic [ERRW-1:0]  ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};
    localparam logic [ERRW-1:0]  ERR_ZERO = {ERRW{1'b0}};

    state_t           state_r;
    state_t           state_s;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] remain_r;
    logic [WIDTH-1:0] expect_r;
    logic [ERRW-1:0]  errcnt_r;
    logic             accept_s;
    logic             mismatch_s;

    function automatic logic [WIDTH-1:0] expect_value(input logic [1:0]       op,
                                                      input logic [WIDTH-1:0] arg,
                                                      input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] v;
        case (op)
            OP_LOAD: v = arg;
            OP_UP:   v = q + arg;
            OP_DOWN: v = q - arg;
            OP_NOP:  v = q;
            default: v = q;
        endcase
        return v;
    endfunction

    // Abort in IDLE blocks acceptance for that cycle.
    assign accept_s   = (state_r == ST_IDLE) && CmdValid && !Abort;
    assign mismatch_s = (state_r == ST_CHECK) && (Q != expect_r);

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (CmdOp)
                        OP_LOAD: state_s = ST_LOAD;
                        OP_UP,
                        OP_DOWN: state_s = (CmdArg != ZERO_W) ? ST_COUNT : ST_CHECK;
                        default: state_s = ST_CHECK;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (Abort) state_s = ST_IDLE;
                else       state_s = ST_CHECK;
            end
            ST_COUNT: begin
                if (Abort)                  state_s = ST_IDLE;
                else if (remain_r == ONE_W) state_s = ST_CHECK;
                else                        state_s = ST_COUNT;
            end
            ST_CHECK: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State, latched command and expected value; remain_r doubles as the load value in LOAD.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_LOAD;
            remain_r <= ZERO_W;
            expect_r <= ZERO_W;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                op_r     <= CmdOp;
                remain_r <= CmdArg;
                expect_r <= expect_value(CmdOp, CmdArg, Q);
            end else if (state_r == ST_COUNT) begin
                remain_r <= remain_r - ONE_W;
            end
        end
    end

    // Saturating mismatch counter, advanced only on a completed check.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            errcnt_r <= ERR_ZERO;
        end else if (mismatch_s && (errcnt_r != ERR_MAX)) begin
            errcnt_r <= errcnt_r + ERR_ONE;
        end
    end

    // Output decode from registered state.
    always_comb begin
        CmdReady = (state_r == ST_IDLE);
        Busy     = (state_r != ST_IDLE);
        Load     = (state_r == ST_LOAD);
        Data     = (state_r == ST_LOAD) ? remain_r : ZERO_W;
        Enable   = (state_r == ST_COUNT);
        UpDn     = (state_r == ST_COUNT) && (op_r == OP_UP);
        Done     = (state_r == ST_CHECK);
        Mismatch = mismatch_s;
        Expect   = expect_r;
        ErrCount = errcnt_r;
    end

endmodule
